keypad_digit_entry: RTL
=======================

# keypad_digit_entry

Scans a 4x4 active-low matrix keypad, debounces each press, and shifts the resulting hex key code into a four-digit register. The register outputs `D3..D0` connect directly to the four-digit 7-segment display driver's digit inputs. The block is the operator entry path for frequency and phase words in the DDS front panel.

## Interface

**Parameters**
- `SCAN_DIV`, default 99999. The scan tick fires every `SCAN_DIV+1` clocks, which is 1 ms at 100 MHz.
- `DEBOUNCE_TICKS`, default 8. Number of consecutive agreeing scan ticks required to accept a press or a release. Legal range is 1..15.

**Ports** (name, direction, width, meaning)
- `clk_100MHz`, in, 1: the only clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `row`, in, 4: keypad rows. Active-low, externally pulled up, asynchronous to the clock.
- `clr`, in, 1: synchronous clear of the digit register.
- `col`, out, 4: keypad column drive. Exactly one bit is low at any time.
- `key_valid`, out, 1: one-cycle pulse for each accepted key press.
- `key_code`, out, 4: code of the most recently accepted key. Held between presses.
- `D3`, `D2`, `D1`, `D0`, out, 4 each: digit register. `D0` holds the newest digit.

## Operation

**Input synchronization**
- `row` passes through a 2-flop synchronizer to produce `row_s`. All sampling uses `row_s`.

**Scan tick**
- A free-running counter runs from 0 to `SCAN_DIV`. `tick` is asserted in the cycle the counter equals `SCAN_DIV`, and the counter wraps to 0 in the next cycle.

**Column drive**
- `col` is 4'b1110, 4'b1101, 4'b1011 or 4'b0111 for column index `ci` = 0, 1, 2 or 3 respectively.

**Key code**
- A valid pattern is a `row_s` value with exactly one 0 bit. The position of that 0 bit is `ri`.
- `key_code = 4*ri + ci`.
- A `row_s` value with two or more 0 bits is treated as no key.

**State machine** (acts only on cycles where `tick` = 1)
- SCAN
  - Valid pattern: latch the pattern and `ci`, set `cnt` = 1, go to DEBOUNCE. `ci` is held.
  - Otherwise: `ci` advances, wrapping 3 to 0.
- DEBOUNCE
  - Pattern equals the latched pattern: `cnt` increments.
  - When `cnt` reaches `DEBOUNCE_TICKS`: accept the key and go to HELD.
  - Pattern differs: go to SCAN and advance `ci`.
- HELD
  - `row_s` = 4'hF: `cnt` increments, starting from 0 on entry.
  - Any other value: `cnt` resets to 0.
  - When `cnt` reaches `DEBOUNCE_TICKS`: go to SCAN and advance `ci`.

**Accept** (registered; takes effect in the cycle after the accepting tick)
- `key_valid` = 1 for exactly one cycle.
- `key_code` is updated.
- The digit register shifts: `D3`←`D2`, `D2`←`D1`, `D1`←`D0`, `D0`←`key_code`.
- When `DEBOUNCE_TICKS` = 1, a press is accepted on the tick that detects it in SCAN.

**Clear**
- `clr` sets `D3..D0` to 0 on the next edge.
- If `clr` and accept fall on the same cycle, `clr` wins: the digits are all 0, but `key_valid` still pulses and `key_code` still updates.

**Key hold and rollover**
- Holding a key produces exactly one `key_valid`. No auto-repeat.
- A second key pressed in another column while in HELD is ignored until full release.

## Timing

**Reset values** (apply immediately when `rst` = 1)
- State SCAN, `ci` = 0, `col` = 4'b1110.
- Tick counter, `cnt`, latched pattern and synchronizer flops all 0. The synchronizer flops then reload with `row` after reset.
- `key_valid` = 0, `key_code` = 0, `D3..D0` = 0.

**Latency**
- For a clean press already stable in `row_s` at the detecting tick, `key_valid` rises one clock after the tick that completes the debounce count. That is `DEBOUNCE_TICKS-1` ticks after the detecting tick.

**Reset mid-operation**
- `rst` during DEBOUNCE or HELD discards the press. After release of `rst`, scanning restarts at column 0.

**Column settling**
- The column changes in the cycle after a tick. Rows are next sampled a full tick period later, which covers the 2-cycle synchronizer delay.

## Structure

**Shared package `keypad_pkg`**
- State encoding (SCAN, DEBOUNCE, HELD).
- The column one-hot table.
- A function mapping a `row_s` pattern and `ci` to a valid flag and a key code.

**Sub-module `scan_tick_gen`**
- Parameterized by `SCAN_DIV`. Inputs are `clk_100MHz` and `rst`; output is `tick`.
- Reused by other front-panel scanners.

## Test plan

All scenarios use `SCAN_DIV`=3 (tick every 4 clocks) and `DEBOUNCE_TICKS`=2 unless stated otherwise.

1. **Reset:** assert `rst` with `row` = 4'hF. Outputs are `col` = 4'b1110, `D3..D0` = 0, `key_valid` = 0. After release, `col` rotates 1110 → 1101 → 1011 → 0111 → 1110 every 4 clocks.
2. **Single press, digit shift:** hold row 2 low whenever `col` = 4'b1101 until release. Expect one `key_valid` pulse with `key_code` = 9 and `D0` = 9. Presses of keys 1, 2 and 3 that follow give `D3..D0` = 9, 1, 2, 3.
3. **Bounce rejection:** press for 1 tick only, then release. No `key_valid`, and scanning resumes at the next column.
4. **Long hold then re-press:** hold one key for 50 ticks. Expect exactly one `key_valid`. Release for 1 tick and press again: still no second pulse. Release for 2 ticks and press again: a second pulse.
5. **Invalid pattern and clr collision:** drive two rows low at once. No accept. Then assert `clr` in the same cycle as an accept: `D3..D0` = 0, and `key_valid` = 1 with `key_code` updated.
6. **Mid-debounce reset:** assert `rst` during DEBOUNCE. No `key_valid`, and `col` = 4'b1110 immediately. Rerun scenario 2 with `DEBOUNCE_TICKS`=1: accept occurs one clock after the detecting tick.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the front-panel keypad scanners: FSM states,
// column drive table and the row-pattern decoder.
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] code;
   } key_t;

   // Column drive patterns packed low-to-high by column index.
   localparam logic [15:0] COL_TABLE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

   function automatic logic [3:0] col_drive(input logic [1:0] ci);
      return COL_TABLE[{ci, 2'b00} +: 4];
   endfunction

   // A single low row identifies the key; anything else counts as no key.
   function automatic key_t decode_key(input logic [3:0] row_s, input logic [1:0] ci);
      key_t k;
      k.valid = 1'b1;
      k.code  = {2'd0, ci};
      case (row_s)
         4'b1110: k.code = {2'd0, ci};
         4'b1101: k.code = {2'd1, ci};
         4'b1011: k.code = {2'd2, ci};
         4'b0111: k.code = {2'd3, ci};
         default: k.valid = 1'b0;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every SCAN_DIV+1 clocks.
module scan_tick_gen #(
   parameter int SCAN_DIV = 99999
) (
   input  logic clk_100MHz,
   input  logic rst,
   output logic tick
);

   localparam int CW = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
   localparam logic [CW-1:0] TOP = CW'(SCAN_DIV);

   logic [CW-1:0] cnt_q;

   assign tick = (cnt_q == TOP);

   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/keypad_digit_entry.sv
// 4x4 keypad scanner with debounce; accepted key codes shift into a
// four-digit register feeding the 7-segment driver.
module keypad_digit_entry
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 99999,
   parameter int DEBOUNCE_TICKS = 8
) (
   input  logic       clk_100MHz,
   input  logic       rst,
   input  logic [3:0] row,
   input  logic       clr,
   output logic [3:0] col,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic [3:0] D3,
   output logic [3:0] D2,
   output logic [3:0] D1,
   output logic [3:0] D0
);

   localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_TICKS);

   logic            tick;
   logic [3:0]      row_meta_q;
   logic [3:0]      row_s_q;
   state_t          state_q, state_d;
   logic [1:0]      ci_q, ci_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [3:0]      cnt_inc;
   logic [3:0]      pat_q, pat_d;
   logic [3:0]      col_q;
   logic            accept;
   key_t            key_dec;
   logic            key_valid_q;
   logic [3:0]      key_code_q;
   logic [3:0][3:0] dig_q;

   scan_tick_gen #(
      .SCAN_DIV(SCAN_DIV)
   ) u_tick (
      .clk_100MHz(clk_100MHz),
      .rst       (rst),
      .tick      (tick)
   );

   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         row_meta_q <= 4'h0;
         row_s_q    <= 4'h0;
      end else begin
         row_meta_q <= row;
         row_s_q    <= row_meta_q;
      end
   end

   assign key_dec = decode_key(row_s_q, ci_q);
   assign cnt_inc = cnt_q + 4'd1;

   always_comb begin
      state_d = state_q;
      ci_d    = ci_q;
      cnt_d   = cnt_q;
      pat_d   = pat_q;
      accept  = 1'b0;
      if (tick) begin
         case (state_q)
            ST_SCAN: begin
               if (key_dec.valid) begin
                  pat_d = row_s_q;
                  // With a single-tick debounce the detecting tick also accepts.
                  if (DB_LIMIT == 4'd1) begin
                     accept  = 1'b1;
                     cnt_d   = 4'd0;
                     state_d = ST_HELD;
                  end else begin
                     cnt_d   = 4'd1;
                     state_d = ST_DEBOUNCE;
                  end
               end else begin
                  ci_d = ci_q + 2'd1;
               end
            end
            ST_DEBOUNCE: begin
               if (row_s_q == pat_q) begin
                  if (cnt_inc == DB_LIMIT) begin
                     accept  = 1'b1;
                     cnt_d   = 4'd0;
                     state_d = ST_HELD;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  cnt_d   = 4'd0;
                  ci_d    = ci_q + 2'd1;
                  state_d = ST_SCAN;
               end
            end
            ST_HELD: begin
               // Column stays parked on the held key, so other columns are invisible here.
               if (row_s_q == 4'hF) begin
                  if (cnt_inc == DB_LIMIT) begin
                     cnt_d   = 4'd0;
                     ci_d    = ci_q + 2'd1;
                     state_d = ST_SCAN;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  cnt_d = 4'd0;
               end
            end
            default: begin
               cnt_d   = 4'd0;
               state_d = ST_SCAN;
            end
         endcase
      end
   end

   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         state_q     <= ST_SCAN;
         ci_q        <= 2'd0;
         cnt_q       <= 4'd0;
         pat_q       <= 4'h0;
         col_q       <= 4'b1110;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
         dig_q       <= '0;
      end else begin
         state_q     <= state_d;
         ci_q        <= ci_d;
         cnt_q       <= cnt_d;
         pat_q       <= pat_d;
         col_q       <= col_drive(ci_d);
         key_valid_q <= accept;
         if (accept) begin
            key_code_q <= key_dec.code;
         end
         if (clr) begin
            dig_q <= '0;
         end else if (accept) begin
            dig_q <= {dig_q[2:0], key_dec.code};
         end
      end
   end

   assign col       = col_q;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign D3        = dig_q[3];
   assign D2        = dig_q[2];
   assign D1        = dig_q[1];
   assign D0        = dig_q[0];

endmodule
